// File: rtl/ext_sram_pkg.sv
// Shared types and helpers for the external SRAM bus controller:
// bus-phase state encoding and halfword-select functions.
package ext_sram_pkg;

   localparam int BUS_W = 16;

   typedef enum logic [2:0] {
      IDLE = 3'd0,
      T1   = 3'd1,
      T2   = 3'd2,
      TW   = 3'd3,
      T3   = 3'd4
   } state_t;

   // A halfword takes part in the transfer only if one of its byte lanes is enabled.
   function automatic logic hw_active(input logic [3:0] be, input logic h);
      return h ? (|be[3:2]) : (|be[1:0]);
   endfunction

   function automatic logic first_hw(input logic [3:0] be);
      return ~(|be[1:0]);
   endfunction

   function automatic logic [BUS_W-1:0] hw_data(input logic [31:0] d, input logic h);
      return h ? d[31:16] : d[15:0];
   endfunction

endpackage

// File: rtl/ext_sram_strobe.sv
// Falling-edge retiming of the address-latch and output-enable strobes,
// so the board latches see clean edges half a cycle after the bus phase starts.
module ext_sram_strobe
   import ext_sram_pkg::*;
(
   input  logic       i_clk,
   input  logic       i_reset,
   input  logic [2:0] i_state,
   input  logic       i_rw,
   output logic       o_ale0,
   output logic       o_ale1,
   output logic       o_oe
);

   logic r_ale0;
   logic r_ale1;
   logic r_oe;

   always_ff @(negedge i_clk) begin
      if (i_reset) begin
         r_ale0 <= 1'b0;
         r_ale1 <= 1'b0;
         r_oe   <= 1'b0;
      end else begin
         r_ale0 <= (i_state == T1);
         r_ale1 <= (i_state == T2);
         r_oe   <= ((i_state == TW) || (i_state == T3)) && !i_rw;
      end
   end

   assign o_ale0 = r_ale0;
   assign o_ale1 = r_ale1;
   assign o_oe   = r_oe;

endmodule

// File: rtl/ext_sram_ctrl.sv
// Word-to-halfword SRAM bus controller: splits a 32-bit request into up to two
// multiplexed address/data bus cycles (T1, T2, TW*, T3) with registered outputs.
module ext_sram_ctrl
   import ext_sram_pkg::*;
#(
   parameter int ADDR_W      = 32,
   parameter int WAIT_STATES = 1
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              valid,
   output logic              ready,
   input  logic              rw,
   input  logic [ADDR_W-1:0] addr,
   input  logic [31:0]       wdata,
   input  logic [3:0]        be,
   output logic [31:0]       rdata,
   output logic              done,
   input  logic [15:0]       din,
   output logic [15:0]       dout,
   output logic              isout,
   output logic              we,
   output logic              oe,
   output logic              bhe,
   output logic              oe_negedge,
   output logic              ale0_negedge,
   output logic              ale1_negedge,
   output logic [2:0]        dbg_state
);

   localparam logic [3:0] WS = 4'(WAIT_STATES);

   state_t      r_state;
   logic        r_rw;
   logic        r_h;
   logic [31:0] r_ha;
   logic [31:0] r_wdata;
   logic [3:0]  r_be;
   logic [3:0]  r_wcnt;
   logic [31:0] r_rdata;
   logic        r_done;
   logic [15:0] r_dout;
   logic        r_isout;
   logic        r_we;
   logic        r_oe;
   logic        r_bhe;

   // Halfword address: word index doubled, zero-extended above ADDR_W.
   logic [ADDR_W-2:0] w_ha_n;
   logic [31:0]       w_ha_in;
   logic              w_first_h;
   logic [31:0]       w_acc_addr;
   logic [31:0]       w_cur_addr;
   logic [31:0]       w_nxt_addr;
   logic              w_ble_n;
   logic              w_bhe;
   logic              w_more;
   logic              w_unused;

   assign w_ha_n     = {addr[ADDR_W-1:2], 1'b0};
   assign w_ha_in    = {{(33-ADDR_W){1'b0}}, w_ha_n};
   assign w_first_h  = first_hw(be);
   assign w_acc_addr = w_ha_in + {31'd0, w_first_h};
   assign w_cur_addr = r_ha + {31'd0, r_h};
   assign w_nxt_addr = r_ha + 32'd1;
   assign w_ble_n    = ~r_be[{r_h, 1'b0}];
   assign w_bhe      = r_be[{r_h, 1'b1}];
   assign w_more     = !r_h && hw_active(r_be, 1'b1);
   assign w_unused   = ^{addr[1:0], w_acc_addr[31:16], w_cur_addr[31], w_nxt_addr[31:16]};

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state <= IDLE;
         r_rw    <= 1'b0;
         r_h     <= 1'b0;
         r_ha    <= '0;
         r_wdata <= '0;
         r_be    <= '0;
         r_wcnt  <= '0;
         r_rdata <= '0;
         r_done  <= 1'b0;
         r_dout  <= '0;
         r_isout <= 1'b0;
         r_we    <= 1'b0;
         r_oe    <= 1'b0;
         r_bhe   <= 1'b0;
      end else begin
         r_done <= 1'b0;
         case (r_state)
            IDLE: begin
               if (valid && ready) begin
                  r_rw    <= rw;
                  r_ha    <= w_ha_in;
                  r_wdata <= wdata;
                  r_be    <= be;
                  r_rdata <= '0;
                  if (be == 4'b0000) begin
                     r_done <= 1'b1;
                  end else begin
                     r_h     <= w_first_h;
                     r_state <= T1;
                     r_dout  <= w_acc_addr[15:0];
                     r_isout <= 1'b1;
                  end
               end
            end
            T1: begin
               r_state <= T2;
               r_dout  <= {w_ble_n, w_cur_addr[30:16]};
               r_wcnt  <= WS;
            end
            T2, TW: begin
               if ((r_state == T2) ? (WS == 4'd0) : (r_wcnt <= 4'd1)) begin
                  r_state <= T3;
               end else begin
                  r_state <= TW;
                  if (r_state == TW) r_wcnt <= r_wcnt - 4'd1;
               end
               r_isout <= r_rw;
               r_dout  <= r_rw ? hw_data(r_wdata, r_h) : 16'h0000;
               r_we    <= r_rw;
               r_oe    <= !r_rw;
               r_bhe   <= w_bhe;
            end
            T3: begin
               if (!r_rw) begin
                  if (r_h) r_rdata[31:16] <= din;
                  else     r_rdata[15:0]  <= din;
               end
               r_we  <= 1'b0;
               r_oe  <= 1'b0;
               r_bhe <= 1'b0;
               // Second halfword follows immediately with its own address phase.
               if (w_more) begin
                  r_h     <= 1'b1;
                  r_state <= T1;
                  r_dout  <= w_nxt_addr[15:0];
                  r_isout <= 1'b1;
               end else begin
                  r_state <= IDLE;
                  r_isout <= 1'b0;
                  r_done  <= 1'b1;
               end
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   ext_sram_strobe u_strobe (
      .i_clk   (clk),
      .i_reset (reset),
      .i_state (r_state),
      .i_rw    (r_rw),
      .o_ale0  (ale0_negedge),
      .o_ale1  (ale1_negedge),
      .o_oe    (oe_negedge)
   );

   // Held low during the done cycle so a request is never taken while done is shown.
   assign ready     = (r_state == IDLE) && !r_done;
   assign rdata     = r_rdata;
   assign done      = r_done;
   assign dout      = r_dout;
   assign isout     = r_isout;
   assign we        = r_we;
   assign oe        = r_oe;
   assign bhe       = r_bhe;
   assign dbg_state = r_state;

endmodule

// File: tb/tb_ext_sram_ctrl.sv
// Directed bench for ext_sram_ctrl: three instances (0, 1 and 3 wait states)
// share the request inputs; traces are recorded per cycle after acceptance.
module tb_ext_sram_ctrl;

   logic        clk = 1'b0;
   logic        reset;
   logic        valid;
   logic        rw;
   logic [31:0] addr;
   logic [31:0] wdata;
   logic [3:0]  be;
   logic [15:0] din;

   logic        d1_ready, d1_done, d1_isout, d1_we, d1_oe, d1_bhe, d1_oen, d1_ale0, d1_ale1;
   logic [31:0] d1_rdata;
   logic [15:0] d1_dout;
   logic [2:0]  d1_state;
   logic        d0_ready, d0_done, d0_isout, d0_we, d0_oe, d0_bhe, d0_oen, d0_ale0, d0_ale1;
   logic [31:0] d0_rdata;
   logic [15:0] d0_dout;
   logic [2:0]  d0_state;
   logic        d3_ready, d3_done, d3_isout, d3_we, d3_oe, d3_bhe, d3_oen, d3_ale0, d3_ale1;
   logic [31:0] d3_rdata;
   logic [15:0] d3_dout;
   logic [2:0]  d3_state;

   int checks   = 0;
   int failures = 0;

   logic [31:0] exp_q[$];

   localparam int TRACE = 24;
   logic [15:0] t_dout[TRACE];
   logic [31:0] t_we, t_oe, t_isout, t_bhe, t_done, t_ready, t_ale0, t_ale1, t_oen;
   int          d1_at, d0_at, d3_at, c0_oen, c3_oen;
   logic [31:0] rd3;

   always #5 clk = ~clk;

   ext_sram_ctrl #(.ADDR_W(32), .WAIT_STATES(1)) u_dut (
      .clk(clk), .reset(reset), .valid(valid), .ready(d1_ready), .rw(rw), .addr(addr),
      .wdata(wdata), .be(be), .rdata(d1_rdata), .done(d1_done), .din(din), .dout(d1_dout),
      .isout(d1_isout), .we(d1_we), .oe(d1_oe), .bhe(d1_bhe), .oe_negedge(d1_oen),
      .ale0_negedge(d1_ale0), .ale1_negedge(d1_ale1), .dbg_state(d1_state)
   );

   ext_sram_ctrl #(.ADDR_W(32), .WAIT_STATES(0)) u_dut_ws0 (
      .clk(clk), .reset(reset), .valid(valid), .ready(d0_ready), .rw(rw), .addr(addr),
      .wdata(wdata), .be(be), .rdata(d0_rdata), .done(d0_done), .din(din), .dout(d0_dout),
      .isout(d0_isout), .we(d0_we), .oe(d0_oe), .bhe(d0_bhe), .oe_negedge(d0_oen),
      .ale0_negedge(d0_ale0), .ale1_negedge(d0_ale1), .dbg_state(d0_state)
   );

   ext_sram_ctrl #(.ADDR_W(32), .WAIT_STATES(3)) u_dut_ws3 (
      .clk(clk), .reset(reset), .valid(valid), .ready(d3_ready), .rw(rw), .addr(addr),
      .wdata(wdata), .be(be), .rdata(d3_rdata), .done(d3_done), .din(din), .dout(d3_dout),
      .isout(d3_isout), .we(d3_we), .oe(d3_oe), .bhe(d3_bhe), .oe_negedge(d3_oen),
      .ale0_negedge(d3_ale0), .ale1_negedge(d3_ale1), .dbg_state(d3_state)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
      end
   endtask

   // Issue one request to all instances and record TRACE cycles after the accept edge.
   task automatic run_req(input logic i_rw, input logic [31:0] i_addr, input logic [31:0] i_wdata,
                          input logic [3:0] i_be, input logic [15:0] i_din0, input logic [15:0] i_din1);
      @(negedge clk); #1;
      check("ready_before_req", {31'd0, d1_ready}, 32'd1);
      valid = 1'b1; rw = i_rw; addr = i_addr; wdata = i_wdata; be = i_be; din = i_din0;
      @(posedge clk); #1;
      valid = 1'b0;
      d1_at = -1; d0_at = -1; d3_at = -1; c0_oen = 0; c3_oen = 0; rd3 = '0;
      t_we = '0; t_oe = '0; t_isout = '0; t_bhe = '0; t_done = '0;
      t_ready = '0; t_ale0 = '0; t_ale1 = '0; t_oen = '0;
      for (int k = 0; k < TRACE; k++) begin
         @(negedge clk); #1;
         t_dout[k] = d1_dout;
         t_we[k] = d1_we; t_oe[k] = d1_oe; t_isout[k] = d1_isout; t_bhe[k] = d1_bhe;
         t_done[k] = d1_done; t_ready[k] = d1_ready;
         t_ale0[k] = d1_ale0; t_ale1[k] = d1_ale1; t_oen[k] = d1_oen;
         if (d1_done && d1_at < 0) begin
            d1_at = k;
            if (!i_rw) begin
               if (exp_q.size() == 0) check("exp_q_underflow", 32'd1, 32'd0);
               else check("rdata", d1_rdata, exp_q.pop_front());
            end
         end
         if (d0_done && d0_at < 0) d0_at = k;
         if (d3_done && d3_at < 0) begin d3_at = k; rd3 = d3_rdata; end
         c0_oen += int'(d0_oen);
         c3_oen += int'(d3_oen);
         if (k == 4) din = i_din1;
      end
   endtask

   initial begin
      int n_done;
      reset = 1'b1; valid = 1'b0; rw = 1'b0; addr = '0; wdata = '0; be = '0; din = '0;
      repeat (3) @(posedge clk);
      @(negedge clk); #1;
      reset = 1'b0;
      check("rst_ready", {31'd0, d1_ready}, 32'd1);
      check("rst_done", {31'd0, d1_done}, 32'd0);
      check("rst_rdata", d1_rdata, 32'd0);
      check("rst_dout", {16'd0, d1_dout}, 32'd0);
      check("rst_strobes", {29'd0, d1_ale0, d1_ale1, d1_oen}, 32'd0);
      check("rst_state", {29'd0, d1_state}, 32'd0);

      // Two-halfword read, 1 wait state
      exp_q.push_back(32'hDEAD_BEEF);
      run_req(1'b0, 32'h0000_1004, 32'h0, 4'b1111, 16'hBEEF, 16'hDEAD);
      check("rd2_t1_dout_h0", {16'd0, t_dout[0]}, 32'h0802);
      check("rd2_t1_isout", {31'd0, t_isout[0]}, 32'd1);
      check("rd2_t2_dout_h0", {16'd0, t_dout[1]}, 32'h0000);
      check("rd2_tw_oe", {31'd0, t_oe[2]}, 32'd1);
      check("rd2_tw_isout", {31'd0, t_isout[2]}, 32'd0);
      check("rd2_t1_dout_h1", {16'd0, t_dout[4]}, 32'h0803);
      check("rd2_t2_dout_h1", {16'd0, t_dout[5]}, 32'h0000);
      check("rd2_done_edges", d1_at, 32'd8);
      check("rd2_done_width", $countones(t_done), 32'd1);
      check("rd2_ale0", t_ale0[8:0], 32'h011);
      check("rd2_ale1", t_ale1[8:0], 32'h022);
      check("rd2_oen_count", $countones(t_oen), 32'd4);
      check("rd2_ws0_done_edges", d0_at, 32'd6);
      check("rd2_ws3_done_edges", d3_at, 32'd12);

      // Low-halfword write
      run_req(1'b1, 32'h0000_0010, 32'h1234_5678, 4'b0011, 16'h0, 16'h0);
      check("wr0_t1_dout", {16'd0, t_dout[0]}, 32'h0008);
      check("wr0_t2_dout", {16'd0, t_dout[1]}, 32'h0000);
      check("wr0_we_count", $countones(t_we), 32'd2);
      check("wr0_we_cycles", t_we[3:0], 32'hC);
      check("wr0_dout_data", {16'd0, t_dout[2]}, 32'h5678);
      check("wr0_dout_t3", {16'd0, t_dout[3]}, 32'h5678);
      check("wr0_bhe", {31'd0, t_bhe[2]}, 32'd1);
      check("wr0_isout_count", $countones(t_isout), 32'd4);
      check("wr0_oe_count", $countones(t_oe), 32'd0);
      check("wr0_done_edges", d1_at, 32'd4);

      // High-halfword only write, upper address bits in use
      run_req(1'b1, 32'h0002_0000, 32'hCAFE_0000, 4'b1000, 16'h0, 16'h0);
      check("wr1_t1_dout", {16'd0, t_dout[0]}, 32'h0001);
      check("wr1_t2_dout", {16'd0, t_dout[1]}, 32'h8001);
      check("wr1_bhe", {31'd0, t_bhe[2]}, 32'd1);
      check("wr1_data", {16'd0, t_dout[2]}, 32'hCAFE);
      check("wr1_done_edges", d1_at, 32'd4);
      check("wr1_idle_dout_hold", {16'd0, t_dout[6]}, 32'hCAFE);

      // Wait-state variants on a single-halfword read
      exp_q.push_back(32'h0000_4242);
      run_req(1'b0, 32'h0000_0040, 32'h0, 4'b0011, 16'h4242, 16'h4242);
      check("ws0_done_edges", d0_at, 32'd3);
      check("ws3_done_edges", d3_at, 32'd6);
      check("ws0_oen_count", c0_oen, 32'd1);
      check("ws3_oen_count", c3_oen, 32'd4);
      check("ws3_rdata", rd3, 32'h0000_4242);
      check("ws1_done_edges", d1_at, 32'd4);

      // Empty byte-enable request
      exp_q.push_back(32'h0);
      run_req(1'b0, 32'h0000_0080, 32'h0, 4'b0000, 16'hFFFF, 16'hFFFF);
      check("be0_done_edges", d1_at, 32'd0);
      check("be0_ready_low", {31'd0, t_ready[0]}, 32'd0);
      check("be0_ready_back", {31'd0, t_ready[1]}, 32'd1);
      check("be0_ale0", $countones(t_ale0), 32'd0);
      check("be0_ale1", $countones(t_ale1), 32'd0);

      // Reset during TW of a read
      @(negedge clk); #1;
      valid = 1'b1; rw = 1'b0; addr = 32'h0000_0100; be = 4'b1111; din = 16'h1111;
      @(posedge clk); #1;
      valid = 1'b0;
      repeat (3) @(negedge clk);
      #1;
      check("rst_mid_in_tw_oe", {31'd0, d1_oe}, 32'd1);
      reset = 1'b1;
      @(posedge clk); #1;
      check("rst_mid_ready", {31'd0, d1_ready}, 32'd1);
      check("rst_mid_bus", {29'd0, d1_oe, d1_we, d1_isout}, 32'd0);
      check("rst_mid_state", {29'd0, d1_state}, 32'd0);
      check("rst_mid_done", {31'd0, d1_done}, 32'd0);
      @(negedge clk); #1;
      check("rst_mid_strobes", {29'd0, d1_ale0, d1_ale1, d1_oen}, 32'd0);
      reset = 1'b0;
      n_done = 0;
      for (int k = 0; k < 10; k++) begin
         @(negedge clk); #1;
         n_done += int'(d1_done);
      end
      check("rst_mid_no_done", n_done, 32'd0);
      check("exp_q_drained", exp_q.size(), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
